inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
// - Instruction fetch stage. Owns the fetch PC and issues word reads to instruction memory.
// - Buffers returned words, each with its PC, in a small in-order FIFO.
// - Delivers instructions to the decode stage over a valid/ready handshake.
// - Accepts PC redirects (branch/jump) from decode. A redirect flushes buffered and in-flight instructions.
// PARAMETERS
// - RESET_PC    32'h0000_0000  fetch address after reset
// - FIFO_DEPTH  4              instruction buffer entries; power of 2, >= 2
// PORTS
// - clk             in   1   clock, rising edge
// - rst             in   1   asynchronous, active-low reset (0 = reset)
// - imem_req        out  1   read request valid
// - imem_addr       out  32  read word address (bits [1:0] always 0)
// - imem_gnt        in   1   memory accepts request this cycle
// - imem_rvalid     in   1   read data valid; responses return in request order
// - imem_rdata      in   32  read data
// - inst_valid      out  1   FIFO head valid
// - inst            out  32  FIFO head instruction
// - inst_pc         out  32  PC of FIFO head
// - inst_ready      in   1   decode consumes head
// - redirect_valid  in   1   redirect fetch (1-cycle pulse)
// - redirect_pc     in   32  new fetch PC
// - fetch_misalign  out  1   misaligned redirect flag (only with FETCH_MISALIGN_CHK_EN)
// BEHAVIOUR
// - Reset values:
//   - fetch_pc = resp_pc = RESET_PC.
//   - FIFO empty; outstanding = discard = 0; state BOOT.
//   - imem_req = 0, imem_addr = RESET_PC.
//   - inst_valid = 0, inst = 32'b0, inst_pc = 0, fetch_misalign = 0.
// - States:
//   - BOOT: one cycle, no request, then RUN.
//   - RUN: normal fetch.
//   - HALT: no requests; exit only via an aligned redirect.
// - Request side:
//   - imem_req = (state==RUN) && !redirect_valid && (fifo_count + outstanding < FIFO_DEPTH).
//   - imem_addr = fetch_pc.
//   - Grant = imem_req && imem_gnt. On grant: fetch_pc += 4 and outstanding++.
//   - While imem_req is high and ungranted, imem_addr is held stable.
// - Response side:
//   - On imem_rvalid: outstanding--.
//   - If discard > 0: drop the word and decrement discard.
//   - Otherwise: push {imem_rdata, resp_pc} and resp_pc += 4.
//   - The credit rule guarantees the FIFO never overflows, so imem_rvalid is never back-pressured.
// - Output side:
//   - inst_valid = !empty; inst and inst_pc show the head entry.
//   - Pop when inst_valid && inst_ready.
//   - When empty, inst = 32'b0.
// - Latency: grant to inst_valid is 1 cycle after imem_rvalid; there is no combinational rdata-to-inst path.
// - Simultaneous push and pop: count unchanged. Push into a full FIFO is impossible (credit rule).
// - Redirect has the highest priority, applied at the clock edge:
//   - FIFO cleared (a same-cycle pop is ignored).
//   - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
//   - discard = outstanding after this cycle's response is retired. A response arriving this cycle is dropped.
//   - A grant cannot coincide with a redirect because imem_req is gated by redirect_valid.
//   - Back-to-back redirects: the last one wins; discard is recomputed each time.
// - Wrap-around: fetch_pc and resp_pc wrap modulo 2^32 silently.
// - Counter widths: outstanding and discard are $clog2(FIFO_DEPTH)+1 bits each.
// - Reset asserted mid-operation clears all state immediately. The memory side shares rst, so stale responses never arrive.
// CONFIGURATION
// - FETCH_MISALIGN_CHK_EN defined:
//   - A redirect with redirect_pc[1:0] != 0 sets fetch_misalign (sticky).
//   - Flushes as a normal redirect, then enters HALT.
//   - An aligned redirect clears the flag and returns to RUN.
// - FETCH_MISALIGN_CHK_EN undefined:
//   - redirect_pc[1:0] ignored; fetch_misalign tied 0; HALT unreachable.
// TESTING
// - Reset, imem_gnt=1, memory returns data 1 cycle after grant, inst_ready=1:
//   -> addrs 0x0,0x4,0x8... issued one per cycle; inst_pc sequence 0x0,0x4,0x8 in order.
// - inst_ready=0, gnt=1:
//   -> exactly FIFO_DEPTH(4) grants, then imem_req=0; after inst_ready=1, fetch resumes at 0x10.
// - imem_gnt=0 for 3 cycles:
//   -> imem_req held 1, imem_addr stable at 0x0; no FIFO push.
// - 2 requests in flight, redirect_pc=0x100:
//   -> both stale responses dropped; next inst_pc=0x100; FIFO empty in the cycle after the redirect.
// - Redirect in the same cycle as imem_rvalid and inst_ready pop:
//   -> response and pop discarded; first delivered inst_pc = redirect target.
// - FETCH_MISALIGN_CHK_EN, redirect_pc=0x102:
//   -> fetch_misalign=1, imem_req=0; then redirect_pc=0x200 -> flag 0, fetch at 0x200.

Source files
------------

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage. Owns the fetch PC, issues word reads to the
// instruction memory, buffers returned words (each tagged with its PC) in a
// small in-order FIFO and hands them to decode over a valid/ready handshake.
// A redirect from decode flushes buffered and in-flight instructions and
// restarts fetch at the new PC.
//
// Parameters
//   RESET_PC    fetch address after reset
//   FIFO_DEPTH  instruction buffer entries (power of 2, >= 2)
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous, active-low reset (0 = reset)
//   imem_req        read request valid
//   imem_addr       read word address (bits [1:0] always 0)
//   imem_gnt        memory accepts the request this cycle
//   imem_rvalid     read data valid; responses return in request order
//   imem_rdata      read data
//   inst_valid      FIFO head valid
//   inst            FIFO head instruction (0 when empty)
//   inst_pc         PC of FIFO head (0 when empty)
//   inst_ready      decode consumes the head
//   redirect_valid  redirect fetch (1-cycle pulse)
//   redirect_pc     new fetch PC
//   fetch_misalign  sticky misaligned-redirect flag
//
// Configuration
//   FETCH_MISALIGN_CHK_EN  when defined, a redirect with redirect_pc[1:0] != 0
//                          sets fetch_misalign and parks fetch in HALT until an
//                          aligned redirect arrives. When undefined the low PC
//                          bits are ignored and fetch_misalign is tied to 0.
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_misalign
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } state_t;

  state_t          state_q, state_d;

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q,  resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q,     discard_d;
  logic [CW-1:0]   count_q,       count_d;
  logic [AW-1:0]   wr_ptr_q,      wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q,      rd_ptr_d;

  logic [31:0]     fifo_inst [FIFO_DEPTH];
  logic [31:0]     fifo_pc   [FIFO_DEPTH];

  logic            grant;
  logic            push;
  logic            drop;
  logic            pop;
  logic            empty;
  logic            redir_misaligned;
  logic [31:0]     redirect_target;
  logic [CW:0]     credit_used;

  // ---------------------------------------------------------------------------
  // Optional misaligned-redirect check
  // ---------------------------------------------------------------------------
`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q;

  assign redir_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // Sticky: only another redirect updates it, and an aligned one clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_q <= 1'b0;
    end else if (redirect_valid) begin
      misalign_q <= redir_misaligned;
    end
  end

  assign fetch_misalign = misalign_q;
`else
  // Low PC bits are simply dropped when the check is compiled out.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs   = ^redirect_pc[1:0];
  assign redir_misaligned = 1'b0;
  assign fetch_misalign   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign empty           = (count_q == '0);

  // Credit rule: never have more words buffered plus in flight than the FIFO
  // can hold, so a response can always be accepted without back-pressure.
  assign credit_used = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req    = (state_q == ST_RUN) && !redirect_valid && (credit_used < CREDITS);
  assign imem_addr   = fetch_pc_q;
  assign grant       = imem_req && imem_gnt;

  // A redirect kills any response arriving in the same cycle and any pop.
  assign push = imem_rvalid && !redirect_valid && (discard_q == '0);
  assign drop = imem_rvalid && !redirect_valid && (discard_q != '0);
  assign pop  = !empty && inst_ready && !redirect_valid;

  assign inst_valid = !empty;
  assign inst       = empty ? 32'b0 : fifo_inst[rd_ptr_q];
  assign inst_pc    = empty ? 32'b0 : fifo_pc[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, otherwise a path that skips the assignment infers a latch.
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
    // Redirect overrides everything; HALT is left only through an aligned one.
    if (redirect_valid) begin
      state_d = redir_misaligned ? ST_HALT : ST_RUN;
    end
  end

  // ---------------------------------------------------------------------------
  // PC, counters and FIFO pointers
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
    count_d       = count_q + CW'(push) - CW'(pop);

    if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (push) begin
      resp_pc_d = resp_pc_q + 32'd4;
      wr_ptr_d  = wr_ptr_q + AW'(1);
    end
    if (drop) begin
      discard_d = discard_q - CW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    // grant is impossible here (imem_req is gated), so the words still owed
    // by memory after this edge are outstanding minus this cycle's response.
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      discard_d  = outstanding_q - CW'(imem_rvalid);
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the values from before the edge, independent of block order.
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // NOTE: the FIFO storage has no reset; entries are only observed through
  // count_q, which is reset, so clearing the array would only cost flops.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr_q] <= imem_rdata;
      fifo_pc[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//
// Self-checking bench for inst_fetch. A behavioural memory returns
// mem_word(addr) for every granted request, in order, after a chosen latency.
// The reference model only knows what decode must see: a contiguous PC stream
// starting at the reset PC or the last redirect target, each word equal to
// mem_word(pc). Directed scenarios cover reset, latency, back-pressure, grant
// stalls, flushes and the misalign option; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_misalign;

  inst_fetch #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_misalign (fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    mem_q[$];
  int          checks;
  int          failures;
  int          cyc;
  int          delivered;
  int          grants;
  logic [31:0] exp_pc;

  logic        obs_req, obs_grant, obs_valid, obs_rvalid, obs_mis;
  logic [31:0] obs_addr, obs_pc, obs_inst;
  logic        prev_stall;
  logic [31:0] prev_addr;
  logic        found;

  logic        r_gnt, r_rdy, r_redir;
  logic [31:0] r_tgt;
  int          r_lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] b(input logic x);
    return {31'b0, x};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, sample #1 later,
  // update the memory model and the delivered-stream model.
  task automatic step(input logic gnt, input logic rdy, input logic redir,
                      input logic [31:0] rpc, input int lat);
    @(negedge clk);
    imem_gnt       = gnt;
    inst_ready     = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    obs_req    = imem_req;
    obs_addr   = imem_addr;
    obs_grant  = imem_req && gnt;
    obs_valid  = inst_valid;
    obs_pc     = inst_pc;
    obs_inst   = inst;
    obs_rvalid = imem_rvalid;
    obs_mis    = fetch_misalign;

    if (obs_req) begin
      check("addr_lsbs", obs_addr & 32'h3, 32'h0);
      if (prev_stall) check("addr_hold", obs_addr, prev_addr);
    end
    if (obs_grant) mem_q.push_back('{addr: obs_addr, due: cyc + 1 + lat});
    if (!obs_valid) check("empty_inst", obs_inst, 32'h0);

    if (redir) begin
      exp_pc = {rpc[31:2], 2'b00};
    end else if (obs_valid && rdy) begin
      check("deliv_pc", obs_pc, exp_pc);
      check("deliv_inst", obs_inst, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end

    prev_stall = obs_req && !gnt;
    prev_addr  = obs_addr;
    cyc++;
  endtask

  // Asserts reset (asynchronously, possibly mid-operation), checks reset
  // values, then releases it and checks the BOOT cycle issues no request.
  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b0;
    imem_gnt       = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    #1;
    check("rst_req",   b(imem_req), 32'h0);
    check("rst_addr",  imem_addr, RESET_PC);
    check("rst_valid", b(inst_valid), 32'h0);
    check("rst_inst",  inst, 32'h0);
    check("rst_pc",    inst_pc, 32'h0);
    check("rst_mis",   b(fetch_misalign), 32'h0);
    mem_q.delete();
    exp_pc     = RESET_PC;
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("boot_noreq", b(imem_req), 32'h0);
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks         = 0;
    failures       = 0;
    cyc            = 0;
    delivered      = 0;
    prev_stall     = 1'b0;
    prev_addr      = 32'h0;
    rst            = 1'b0;
    imem_gnt       = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    exp_pc         = RESET_PC;

    // Streaming: one request per cycle, data 1 cycle after grant, always ready.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 0);
      check("t1_req",  b(obs_req), 32'h1);
      check("t1_addr", obs_addr, 32'(4 * i));
      if (i < 2) begin
        check("t1_latency_empty", b(obs_valid), 32'h0);
      end else begin
        check("t1_valid", b(obs_valid), 32'h1);
        check("t1_pc",    obs_pc, 32'(4 * (i - 2)));
      end
    end

    // Decode stalled: exactly DEPTH grants, then requests stop.
    do_reset();
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 0);
      if (obs_grant) grants++;
    end
    check("t2_grants",  32'(grants), 32'(DEPTH));
    check("t2_req_off", b(obs_req), 32'h0);
    check("t2_head_pc", obs_pc, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 0);
      if (obs_grant) begin
        found = 1'b1;
        check("t2_resume_addr", obs_addr, 32'h10);
      end
    end
    check("t2_resume_seen", b(found), 32'h1);

    // Memory refuses grants: request held with a stable address.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 0);
      check("t3_req",   b(obs_req), 32'h1);
      check("t3_addr",  obs_addr, 32'h0);
      check("t3_empty", b(obs_valid), 32'h0);
    end

    // Two requests in flight when a redirect arrives.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0, 2);
    step(1'b1, 1'b0, 1'b0, 32'h0, 2);
    check("t4_inflight", 32'(mem_q.size()), 32'h2);
    step(1'b1, 1'b1, 1'b1, 32'h100, 0);
    check("t4_redir_noreq", b(obs_req), 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 0);
    check("t4_flushed", b(obs_valid), 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 0);
      if (obs_valid) begin
        found = 1'b1;
        check("t4_first_pc", obs_pc, 32'h100);
      end
    end
    check("t4_delivered", b(found), 32'h1);

    // Redirect coinciding with a response and a pop.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 0);
    step(1'b1, 1'b1, 1'b1, 32'h200, 0);
    check("t5_rvalid_same_cycle", b(obs_rvalid), 32'h1);
    check("t5_pop_same_cycle",    b(obs_valid), 32'h1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 0);
      if (obs_valid) begin
        found = 1'b1;
        check("t5_first_pc", obs_pc, 32'h200);
      end
    end
    check("t5_delivered", b(found), 32'h1);

    // Misaligned redirect.
    do_reset();
    step(1'b1, 1'b1, 1'b1, 32'h102, 0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 0);
`ifdef FETCH_MISALIGN_CHK_EN
    check("t6_flag_set", b(obs_mis), 32'h1);
    check("t6_halt_req", b(obs_req), 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 0);
    check("t6_halt_hold", b(obs_req), 32'h0);
    check("t6_flag_hold", b(obs_mis), 32'h1);
    step(1'b1, 1'b1, 1'b1, 32'h200, 0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 0);
    check("t6_flag_clr", b(obs_mis), 32'h0);
    check("t6_run_req",  b(obs_req), 32'h1);
    check("t6_run_addr", obs_addr, 32'h200);
`else
    check("t6_flag_tied", b(obs_mis), 32'h0);
    check("t6_req",       b(obs_req), 32'h1);
    check("t6_addr",      obs_addr, 32'h100);
`endif

    // Randomized traffic: random grants, ready, latency and redirects,
    // including targets near the top of the address space to exercise wrap.
    do_reset();
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      r_gnt   = ($urandom_range(0, 9) < 7);
      r_rdy   = ($urandom_range(0, 9) < 7);
      r_redir = ($urandom_range(0, 99) < 3);
      r_lat   = $urandom_range(0, 3);
      r_tgt   = $urandom;
      if ($urandom_range(0, 3) == 0) r_tgt = 32'hFFFF_FFF4 | (r_tgt & 32'h3);
`ifdef FETCH_MISALIGN_CHK_EN
      r_tgt[1:0] = 2'b00;
`endif
      step(r_gnt, r_rdy, r_redir, r_tgt, r_lat);
    end
    check("rand_progress", b(delivered > 200), 32'h1);

    // Reset while busy clears everything at once.
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
